// File: rtl/send_packet_gen.sv
// send_packet_gen: reads length-prefixed packets from RAM and streams them to the MAC TX FIFO.
// Define SEND_PKT_PAD_EN to pad packets shorter than 60 bytes with zero bytes.
module send_packet_gen #(
    parameter int TX_W      = 8,
    parameter int RAM_AW    = 10,
    parameter int CMD_DEPTH = 4,
    parameter int MAX_LEN   = 1518
) (
    input  logic              clk_original,
    input  logic              rst,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_chipselect,
    output logic              ram_write,
    input  logic [31:0]       ram_readdata,
    output logic [31:0]       ram_writedata,
    output logic [3:0]        ram_byteenable,
    input  logic              ram_waitrequest,
    output logic [TX_W-1:0]   ff_tx_data,
    output logic              ff_tx_sop,
    output logic              ff_tx_eop,
    output logic [1:0]        ff_tx_mod,
    output logic              ff_tx_err,
    output logic              ff_tx_wren,
    input  logic              ff_tx_rdy,
    input  logic [24:0]       start_ram_addr,
    input  logic              cmd_send,
    output logic              busy,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              cmd_overflow
);
    localparam int PW = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, RD, TX} state_t;
    state_t state, state_n;

    logic [RAM_AW-1:0] fifo [CMD_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic [RAM_AW-1:0] base, widx;
    logic [15:0]       len, tot, sent;
    logic [31:0]       wbuf, masked;
    logic [1:0]        lane;
    logic              empty, full, pop, push, xfer, eop, last_lane, rd_need, bad_len;
    logic              unused_addr;

    assign unused_addr = ^start_ram_addr[24:RAM_AW];

`ifdef SEND_PKT_PAD_EN
    assign tot = (len < 16'd60) ? 16'd60 : len;
`else
    assign tot = len;
`endif

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
    assign pop       = state == IDLE && !empty;
    assign push      = cmd_send && (!full || pop);
    assign rd_need   = sent < len;
    assign bad_len   = ram_readdata[15:0] == 16'd0 || ram_readdata[15:0] > 16'(MAX_LEN);
    assign xfer      = ff_tx_wren && ff_tx_rdy;
    assign eop       = state == TX && (sent + 16'(TX_W / 8) >= tot);
    assign last_lane = lane == 2'd3 || TX_W == 32;

    assign ram_chipselect = state == HDR || (state == RD && rd_need);
    assign ram_addr       = base + widx;
    assign ram_write      = 1'b0;
    assign ram_writedata  = 32'h0;
    assign ram_byteenable = 4'hF;
    assign ff_tx_err      = 1'b0;
    assign ff_tx_wren     = state == TX;
    assign ff_tx_sop      = ff_tx_wren && sent == 16'd0;
    assign ff_tx_eop      = eop;
    assign busy           = state != IDLE || !empty;

    if (TX_W == 8) begin : g_w8
        assign ff_tx_data = wbuf[8*lane +: 8];
        assign ff_tx_mod  = 2'd0;
    end else begin : g_w32
        assign ff_tx_data = {wbuf[7:0], wbuf[15:8], wbuf[23:16], wbuf[31:24]};
        assign ff_tx_mod  = eop ? 2'd0 - tot[1:0] : 2'd0;
    end

    // bytes past the real length are zeroed: padding and unused eop lanes
    always_comb begin
        masked = 32'h0;
        for (int j = 0; j < 4; j++)
            masked[8*j +: 8] = (sent + 16'(j) < len) ? ram_readdata[8*j +: 8] : 8'h00;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = empty ? IDLE : HDR;
            HDR:  state_n = ram_waitrequest ? HDR : bad_len ? IDLE : RD;
            RD:   state_n = (rd_need && ram_waitrequest) ? RD : TX;
            TX:   state_n = !ff_tx_rdy ? TX : eop ? IDLE : last_lane ? RD : TX;
        endcase
    end

    always_ff @(posedge clk_original or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            base         <= '0;
            widx         <= '0;
            len          <= '0;
            sent         <= '0;
            wbuf         <= '0;
            lane         <= '0;
            pkt_done     <= 1'b0;
            pkt_err      <= 1'b0;
            cmd_overflow <= 1'b0;
        end else begin
            pkt_done     <= xfer && eop;
            pkt_err      <= state == HDR && !ram_waitrequest && bad_len;
            cmd_overflow <= cmd_send && full && !pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                base   <= fifo[rd_ptr[PW-1:0]];
                widx   <= '0;
                sent   <= '0;
            end
            if (state == HDR && !ram_waitrequest) begin
                len  <= ram_readdata[15:0];
                widx <= RAM_AW'(1);
            end
            if (state == RD && state_n == TX) begin
                wbuf <= masked;
                lane <= 2'd0;
            end
            if (xfer) begin
                sent <= sent + 16'(TX_W / 8);
                lane <= lane + 2'd1;
                if (last_lane && !eop) widx <= widx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_original)
        if (push) fifo[wr_ptr[PW-1:0]] <= start_ram_addr[RAM_AW-1:0];
endmodule

// File: tb/tb_send_packet_gen.sv
// tb_send_packet_gen: runs 8-bit and 32-bit builds side by side against a byte-level packet model.
module tb_send_packet_gen;
    localparam int MAXL = 1518;

    logic        clk = 1'b0, rst = 1'b1, cmd_send = 1'b0;
    logic [24:0] start_addr = '0;
    logic [31:0] mem [1024];
    logic [9:0]  addr [2];
    logic        cs [2], wr [2], wait_r [2], sop [2], eop [2], err_o [2], wren [2], rdy [2];
    logic        busy [2], done [2], perr [2], ovf [2];
    logic [31:0] rdata [2], wdata [2], data [2];
    logic [3:0]  be [2];
    logic [1:0]  mod [2];
    logic [7:0]  d8;
    logic [31:0] d32;

    always #5 clk = ~clk;

    assign rdata[0] = mem[addr[0]];
    assign rdata[1] = mem[addr[1]];
    assign data[0]  = {24'h0, d8};
    assign data[1]  = d32;

    send_packet_gen #(.TX_W(8)) dut8 (
        .clk_original(clk), .rst(rst), .ram_addr(addr[0]), .ram_chipselect(cs[0]), .ram_write(wr[0]),
        .ram_readdata(rdata[0]), .ram_writedata(wdata[0]), .ram_byteenable(be[0]),
        .ram_waitrequest(wait_r[0]), .ff_tx_data(d8), .ff_tx_sop(sop[0]), .ff_tx_eop(eop[0]),
        .ff_tx_mod(mod[0]), .ff_tx_err(err_o[0]), .ff_tx_wren(wren[0]), .ff_tx_rdy(rdy[0]),
        .start_ram_addr(start_addr), .cmd_send(cmd_send), .busy(busy[0]), .pkt_done(done[0]),
        .pkt_err(perr[0]), .cmd_overflow(ovf[0]));

    send_packet_gen #(.TX_W(32)) dut32 (
        .clk_original(clk), .rst(rst), .ram_addr(addr[1]), .ram_chipselect(cs[1]), .ram_write(wr[1]),
        .ram_readdata(rdata[1]), .ram_writedata(wdata[1]), .ram_byteenable(be[1]),
        .ram_waitrequest(wait_r[1]), .ff_tx_data(d32), .ff_tx_sop(sop[1]), .ff_tx_eop(eop[1]),
        .ff_tx_mod(mod[1]), .ff_tx_err(err_o[1]), .ff_tx_wren(wren[1]), .ff_tx_rdy(rdy[1]),
        .start_ram_addr(start_addr), .cmd_send(cmd_send), .busy(busy[1]), .pkt_done(done[1]),
        .pkt_err(perr[1]), .cmd_overflow(ovf[1]));

    int n_tests = 0, n_fail = 0;
    int exp_done = 0, exp_err = 0, exp_ovf = 0;
    int n_done [2] = '{0, 0};
    int n_err [2]  = '{0, 0};
    int n_ovf [2]  = '{0, 0};
    int beats [2]  = '{0, 0};
    int stall [2]  = '{0, 0};
    bit rnd_rdy = 1'b0, rnd_wait = 1'b0;
    logic [35:0] expq [2][$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected beats {data, sop, eop, mod} for both widths, built from the byte sequence
    task automatic expect_pkt(input int base);
        int l, n;
        logic [31:0] w, d;
        logic [7:0] b [$];
        w = mem[base % 1024];
        l = int'(w[15:0]);
        if (l == 0 || l > MAXL) begin
            exp_err++;
            return;
        end
        n = l;
`ifdef SEND_PKT_PAD_EN
        if (n < 60) n = 60;
`endif
        for (int k = 0; k < n; k++) begin
            w = mem[(base + 1 + k / 4) % 1024];
            b.push_back(k < l ? w[8*(k%4) +: 8] : 8'h00);
        end
        for (int k = 0; k < n; k++)
            expq[0].push_back({24'h0, b[k], k == 0, k == n - 1, 2'b00});
        for (int k = 0; k < n; k += 4) begin
            d = 32'h0;
            for (int j = 0; j < 4; j++)
                if (k + j < n) d[31 - 8*j -: 8] = b[k + j];
            expq[1].push_back({d, k == 0, k + 4 >= n, (k + 4 >= n) ? 2'((4 - n % 4) % 4) : 2'b00});
        end
        exp_done++;
    endtask

    logic        hold_v [2], ahold_v [2], due [2];
    logic [35:0] hold_b [2];
    logic [9:0]  ahold_a [2];

    always @(negedge clk) begin
        logic [35:0] cur, e;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall[i] > 0) begin
                wait_r[i] = 1'b1;
                stall[i]--;
            end else if (rnd_wait && $urandom_range(0, 3) == 0) begin
                wait_r[i] = 1'b1;
                stall[i] = 1;
            end else wait_r[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            cur = {data[i], sop[i], eop[i], mod[i]};
            if (rst) begin
                expq[i].delete();
                hold_v[i] = 1'b0;
                ahold_v[i] = 1'b0;
                due[i] = 1'b0;
                beats[i] = 0;
            end else begin
                if (hold_v[i]) check(i == 0 ? "hold8" : "hold32", {wren[i], cur}, {1'b1, hold_b[i]});
                if (ahold_v[i]) check("addr_hold", {cs[i], addr[i]}, {1'b1, ahold_a[i]});
                check(i == 0 ? "pkt_done8" : "pkt_done32", done[i], due[i]);
                n_done[i] += int'(done[i]);
                n_err[i] += int'(perr[i]);
                n_ovf[i] += int'(ovf[i]);
                hold_v[i] = wren[i] && !rdy[i];
                hold_b[i] = cur;
                ahold_v[i] = cs[i] && wait_r[i];
                ahold_a[i] = addr[i];
                due[i] = 1'b0;
                if (wren[i] && rdy[i]) begin
                    check("beat_expected", expq[i].size() > 0, 1);
                    if (expq[i].size() > 0) begin
                        e = expq[i].pop_front();
                        check(i == 0 ? "beat8" : "beat32", cur, e);
                        due[i] = e[2];
                        beats[i] = e[2] ? 0 : beats[i] + 1;
                    end
                end
            end
        end
    end

    task automatic send(input int base, input bit kept);
        @(negedge clk);
        start_addr = 25'(base);
        cmd_send = 1'b1;
        if (kept) expect_pkt(base);
        @(negedge clk);
        cmd_send = 1'b0;
    endtask

    task automatic put_pkt(input int base, input int l);
        mem[base % 1024] = {16'($urandom), 16'(l)};
        for (int w = 1; w <= (l + 3) / 4; w++) mem[(base + w) % 1024] = $urandom;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy[0] || busy[1] || expq[0].size() != 0 || expq[1].size() != 0) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", c < 20000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts();
        for (int i = 0; i < 2; i++) begin
            check("done_count", n_done[i], exp_done);
            check("err_count", n_err[i], exp_err);
            check("ovf_count", n_ovf[i], exp_ovf);
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check("rst_ctl", {addr[i], cs[i], wren[i], sop[i], eop[i], mod[i], busy[i], done[i],
                              perr[i], ovf[i], wr[i], err_o[i], be[i]}, 64'hF);
            check("rst_data", {data[i], wdata[i]}, 64'h0);
        end
    endtask

    initial begin
        int c, base, l;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        #2 check_reset_outputs();
        @(negedge clk);
        #2 rst = 1'b0;

        mem[10] = 32'd5;
        mem[11] = 32'h44332211;
        mem[12] = 32'h55;
        send(10, 1);
        wait_idle();

        mem[20] = 32'hABCD0006;
        mem[21] = 32'h44332211;
        mem[22] = 32'h6655;
        send(20, 1);
        wait_idle();

        rnd_rdy = 1'b1;
        rnd_wait = 1'b1;
        send(10, 1);
        wait_idle();
        check_counts();

        put_pkt(100, 400);
        for (int j = 0; j < 5; j++) put_pkt(300 + 10 * j, $urandom_range(1, 36));
        send(100, 1);
        repeat (5) @(negedge clk);
        for (int j = 0; j < 5; j++) send(300 + 10 * j, j < 4);
        exp_ovf++;
        wait_idle();
        check_counts();

        mem[400] = 32'h12340000;
        mem[410] = 32'(MAXL + 1);
        send(400, 1);
        send(410, 1);
        wait_idle();
        rnd_rdy = 1'b0;
        put_pkt(0, MAXL);
        send(0, 1);
        wait_idle();
        check_counts();

        put_pkt(500, 100);
        send(500, 1);
        c = 0;
        while (beats[0] < 3 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("beat3_timeout", c < 5000, 1);
        #2 rst = 1'b1;
        exp_done--;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        put_pkt(600, 5);
        send(600, 1);
        wait_idle();
        check_counts();

        rnd_rdy = 1'b1;
        for (int t = 0; t < 25; t++) begin
            base = (t == 0) ? 1020 : $urandom_range(0, 1023);
            l = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : MAXL + 1 + $urandom_range(0, 50))
                                            : $urandom_range(1, 90);
            put_pkt(base, (l > MAXL) ? 0 : l);
            mem[base % 1024][15:0] = 16'(l);
            send(base, 1);
            wait_idle();
        end
        check_counts();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
